// File: rtl/paddsb_pkg.sv
// paddsb_pkg: shared definitions for the packed-lane signed add/sub pipeline.
//   - op encodings (OP_ADD_WRAP .. OP_SUB_SAT) and op field decoders
//   - nlanes(): number of lanes for a given operand/lane width
//   - sat_max()/sat_min(): signed saturation limits for a lane width,
//     returned zero-extended to 64 bits; callers slice the low lane_w bits.
package paddsb_pkg;

  localparam logic [1:0] OP_ADD_WRAP = 2'b00;
  localparam logic [1:0] OP_ADD_SAT  = 2'b01;
  localparam logic [1:0] OP_SUB_WRAP = 2'b10;
  localparam logic [1:0] OP_SUB_SAT  = 2'b11;

  function automatic int nlanes(input int data_w, input int lane_w);
    return data_w / lane_w;
  endfunction

  // Largest positive value of a lane: 0111..1
  function automatic logic [63:0] sat_max(input int lane_w);
    return (64'd1 << (lane_w - 1)) - 64'd1;
  endfunction

  // Most negative value of a lane: 1000..0
  function automatic logic [63:0] sat_min(input int lane_w);
    return 64'd1 << (lane_w - 1);
  endfunction

  // Bit 1 of op selects subtract, bit 0 selects saturation.
  function automatic logic op_is_sub(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_sat(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/paddsb_lane.sv
// paddsb_lane: combinational add/sub of one signed lane with overflow
// detection and optional saturation.
// Ports:
//   a, b  in  LANE_W  lane operands (two's complement)
//   sub   in  1       1 = a - b, 0 = a + b
//   sat   in  1       1 = clamp on overflow, 0 = keep wrapped result
//   res   out LANE_W  lane result
//   ovf   out 1       signed overflow of the raw result (reported in both modes)
module paddsb_lane
  import paddsb_pkg::*;
#(
  parameter int LANE_W = 4
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              sub,
  input  logic              sat,
  output logic [LANE_W-1:0] res,
  output logic              ovf
);

  localparam logic [63:0]       MAX_FULL = sat_max(LANE_W);
  localparam logic [63:0]       MIN_FULL = sat_min(LANE_W);
  localparam logic [LANE_W-1:0] LANE_MAX = MAX_FULL[LANE_W-1:0];
  localparam logic [LANE_W-1:0] LANE_MIN = MIN_FULL[LANE_W-1:0];

  logic [LANE_W-1:0] b_eff;
  logic [LANE_W-1:0] raw;

  // Lane arithmetic: subtract is a + ~b + 1. Comparing sign(a) against the
  // sign of the effective addend covers both the add and sub overflow rules.
  always_comb begin
    b_eff = sub ? ~b : b;
    raw   = a + b_eff + {{(LANE_W-1){1'b0}}, sub};
    ovf   = (a[LANE_W-1] == b_eff[LANE_W-1]) && (raw[LANE_W-1] != a[LANE_W-1]);
    if (sat && ovf) begin
      res = a[LANE_W-1] ? LANE_MIN : LANE_MAX;
    end else begin
      res = raw;
    end
  end

endmodule

// File: rtl/paddsb_pipe.sv
// paddsb_pipe: two-stage pipelined packed-lane signed add/sub with per-lane
// saturate/wrap mode, valid/ready handshake and sticky overflow statistics.
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   in_valid/ready   operand beat handshake (a, b, op)
//   a, b             DATA_W operands, lanes packed LSB-first
//   op               00 add-wrap, 01 add-sat, 10 sub-wrap, 11 sub-sat
//   out_valid/ready  result beat handshake (sum, lane_ovf, err)
//   sum              packed per-lane result
//   lane_ovf         per-lane signed overflow of the current result
//   err              OR of lane_ovf
//   clr_stats        synchronous clear of sticky_err / ovf_cnt (wins over an event)
//   sticky_err       set by any transferred result beat with err=1
//   ovf_cnt          saturating count of transferred result beats with err=1
module paddsb_pipe
  import paddsb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LANE_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        a,
  input  logic [DATA_W-1:0]        b,
  input  logic [1:0]               op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        sum,
  output logic [DATA_W/LANE_W-1:0] lane_ovf,
  output logic                     err,
  input  logic                     clr_stats,
  output logic                     sticky_err,
  output logic [CNT_W-1:0]         ovf_cnt
);

  localparam int NLANES = nlanes(DATA_W, LANE_W);

  // Reject geometries that would let a lane straddle the operand boundary.
  if ((DATA_W % LANE_W) != 0) begin : g_bad_data_w
    $error("paddsb_pipe: DATA_W must be a multiple of LANE_W");
  end
  if (LANE_W < 2) begin : g_bad_lane_w
    $error("paddsb_pipe: LANE_W must be at least 2");
  end

  logic              s1_valid;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [1:0]        s1_op;
  logic              s1_sub;
  logic              s1_sat;
  logic              s1_adv;
  logic              s2_adv;
  logic              xfer_err;
  logic [DATA_W-1:0] calc_sum;
  logic [NLANES-1:0] calc_ovf;

  // Handshake: a stage may advance when it is empty or its successor advances.
  always_comb begin
    s2_adv   = !out_valid || out_ready;
    s1_adv   = !s1_valid || s2_adv;
    in_ready = s1_adv;
    xfer_err = out_valid && out_ready && err;
    s1_sub   = op_is_sub(s1_op);
    s1_sat   = op_is_sat(s1_op);
  end

  // Stage 1: capture operands and op on an input transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= {DATA_W{1'b0}};
      s1_b     <= {DATA_W{1'b0}};
      s1_op    <= 2'b00;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= a;
        s1_b  <= b;
        s1_op <= op;
      end
    end
  end

  // Independent lanes between S1 and S2; no carry crosses a lane boundary.
  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    paddsb_lane #(.LANE_W(LANE_W)) u_lane (
      .a   (s1_a[i*LANE_W +: LANE_W]),
      .b   (s1_b[i*LANE_W +: LANE_W]),
      .sub (s1_sub),
      .sat (s1_sat),
      .res (calc_sum[i*LANE_W +: LANE_W]),
      .ovf (calc_ovf[i])
    );
  end

  // Stage 2: register lane results; they hold while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= {DATA_W{1'b0}};
      lane_ovf  <= {NLANES{1'b0}};
      err       <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum      <= calc_sum;
        lane_ovf <= calc_ovf;
        err      <= |calc_ovf;
      end
    end
  end

  // Overflow statistics: clear has priority, counter saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_err <= 1'b0;
      ovf_cnt    <= {CNT_W{1'b0}};
    end else if (clr_stats) begin
      sticky_err <= 1'b0;
      ovf_cnt    <= {CNT_W{1'b0}};
    end else if (xfer_err) begin
      sticky_err <= 1'b1;
      if (ovf_cnt != {CNT_W{1'b1}}) begin
        ovf_cnt <= ovf_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
